// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the
// non-pipelined core. Runs ifetch/dmem req-ack handshakes, gates regfile,
// PC and memory writes, and handles BRK (debug halt) and SYS (ecall) traps.
//
// Ports:
//   i_clk, i_rstn     clock, asynchronous active-low reset
//   i_ctrlSigs[12:0]  decoder word [12]BRK [11]SYS [10:7]ALU_OP [6]EXEC_A
//                     [5]EXEC_B [4]MEM_W [3]REG_W [2]MEM2REG [1]BRA [0]JMP
//   i_ifetchAck       instruction memory ack
//   i_dmemAck         data memory ack
//   i_haltReq         external halt request (level, sampled in IDLE/WB)
//   i_resume          leave HALT (pulse)
//   i_ecallAck        ecall serviced
//   o_ifetchReq       fetch request
//   o_irLoad          latch fetched instruction (FETCH & i_ifetchAck)
//   o_dmemReq         data memory request
//   o_dmemWe          data memory write enable
//   o_regWe           register file write strobe
//   o_pcUpdate        commit next PC
//   o_retire          instruction retired
//   o_ctrlLat[12:0]   control word latched in DECODE
//   o_halted          core in HALT
//   o_ecall           ecall pending
//   o_busErr          bus timeout flag
//
// Optional feature: define SEQ_BUS_TIMEOUT_EN to enable the bus-ack
// watchdog (limit TIMEOUT_CYCLES). Without it o_busErr stays 0.

module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [12:0] i_ctrlSigs,
    input  logic        i_ifetchAck,
    input  logic        i_dmemAck,
    input  logic        i_haltReq,
    input  logic        i_resume,
    input  logic        i_ecallAck,
    output logic        o_ifetchReq,
    output logic        o_irLoad,
    output logic        o_dmemReq,
    output logic        o_dmemWe,
    output logic        o_regWe,
    output logic        o_pcUpdate,
    output logic        o_retire,
    output logic [12:0] o_ctrlLat,
    output logic        o_halted,
    output logic        o_ecall,
    output logic        o_busErr
);

    localparam int B_BRK   = 12;
    localparam int B_SYS   = 11;
    localparam int B_MEMW  = 4;
    localparam int B_REGW  = 3;
    localparam int B_M2R   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_SYS
    } state_t;

    typedef enum logic [1:0] {
        C_EXT,
        C_BRK,
        C_BUS
    } cause_t;

    state_t      state_q;
    state_t      state_d;
    cause_t      cause_q;
    cause_t      cause_d;
    logic [12:0] ctrl_d;
    logic        limit_hit;
    logic        bus_to;

`ifdef SEQ_BUS_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Counts waiting cycles of the current FETCH/MEM visit; any state
    // change restarts it, so each entry begins a fresh transaction.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q == S_FETCH || state_q == S_MEM) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign limit_hit = (cnt_q == LIMIT);
`else
    // Never true: the watchdog is absent, waits are unbounded.
    assign limit_hit = (TIMEOUT_CYCLES < 0);
`endif

    assign o_irLoad = (state_q == S_FETCH) & i_ifetchAck;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ctrl_d  = o_ctrlLat;
        bus_to  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_haltReq) begin
                    state_d = S_HALT;
                    cause_d = C_EXT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // An ack on the limit cycle wins over the timeout.
                if (i_ifetchAck) begin
                    state_d = S_DECODE;
                end else if (limit_hit) begin
                    state_d = S_HALT;
                    cause_d = C_BUS;
                    bus_to  = 1'b1;
                end
            end
            S_DECODE: begin
                ctrl_d = i_ctrlSigs;
                if (i_ctrlSigs[B_BRK]) begin
                    state_d = S_HALT;
                    cause_d = C_BRK;
                end else if (i_ctrlSigs[B_SYS]) begin
                    state_d = S_SYS;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (o_ctrlLat[B_MEMW] | o_ctrlLat[B_M2R]) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (i_dmemAck) begin
                    state_d = S_WB;
                end else if (limit_hit) begin
                    state_d = S_HALT;
                    cause_d = C_BUS;
                    bus_to  = 1'b1;
                end
            end
            S_WB: begin
                if (i_haltReq) begin
                    state_d = S_HALT;
                    cause_d = C_EXT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                // A BRK retires on resume; other causes refetch.
                if (i_resume) begin
                    if (cause_q == C_BRK) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_SYS: begin
                if (i_ecallAck) begin
                    state_d = S_WB;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            cause_q     <= C_EXT;
            o_ctrlLat   <= '0;
            o_ifetchReq <= 1'b0;
            o_dmemReq   <= 1'b0;
            o_dmemWe    <= 1'b0;
            o_regWe     <= 1'b0;
            o_pcUpdate  <= 1'b0;
            o_retire    <= 1'b0;
            o_halted    <= 1'b0;
            o_ecall     <= 1'b0;
            o_busErr    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            o_ctrlLat   <= ctrl_d;
            o_ifetchReq <= (state_d == S_FETCH);
            o_dmemReq   <= (state_d == S_MEM);
            o_dmemWe    <= (state_d == S_MEM) & ctrl_d[B_MEMW];
            o_regWe     <= (state_d == S_WB) & ctrl_d[B_REGW];
            o_pcUpdate  <= (state_d == S_WB);
            o_retire    <= (state_d == S_WB);
            o_halted    <= (state_d == S_HALT);
            o_ecall     <= (state_d == S_SYS);
            if (state_q == S_HALT && i_resume) begin
                o_busErr <= 1'b0;
            end else if (bus_to) begin
                o_busErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed testbench for core_sequencer: ALU, load/store, BRK, ecall,
// external halt, async reset mid-MEM and the bus watchdog (when built in).

module tb_core_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b1;
    logic [12:0] i_ctrlSigs = '0;
    logic        i_ifetchAck = 1'b0;
    logic        i_dmemAck = 1'b0;
    logic        i_haltReq = 1'b0;
    logic        i_resume = 1'b0;
    logic        i_ecallAck = 1'b0;
    logic        o_ifetchReq;
    logic        o_irLoad;
    logic        o_dmemReq;
    logic        o_dmemWe;
    logic        o_regWe;
    logic        o_pcUpdate;
    logic        o_retire;
    logic [12:0] o_ctrlLat;
    logic        o_halted;
    logic        o_ecall;
    logic        o_busErr;

    int n_checks = 0;
    int n_fail = 0;

    // {ifetchReq, irLoad, dmemReq, dmemWe, regWe,
    //  pcUpdate, retire, halted, ecall, busErr}
    localparam logic [9:0] O_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] O_FETCH = 10'b10_0000_0000;
    localparam logic [9:0] O_FACK  = 10'b11_0000_0000;
    localparam logic [9:0] O_MEMR  = 10'b00_1000_0000;
    localparam logic [9:0] O_MEMW  = 10'b00_1100_0000;
    localparam logic [9:0] O_WBRW  = 10'b00_0011_1000;
    localparam logic [9:0] O_WB    = 10'b00_0001_1000;
    localparam logic [9:0] O_HALT  = 10'b00_0000_0100;
    localparam logic [9:0] O_ECALL = 10'b00_0000_0010;
    localparam logic [9:0] O_HBUS  = 10'b00_0000_0101;

    localparam logic [12:0] W_ADDI = 13'h0028;
    localparam logic [12:0] W_LW   = 13'h002C;
    localparam logic [12:0] W_SW   = 13'h0030;
    localparam logic [12:0] W_BRK  = 13'h1000;
    localparam logic [12:0] W_SYS  = 13'h0800;

    core_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_ctrlSigs  (i_ctrlSigs),
        .i_ifetchAck (i_ifetchAck),
        .i_dmemAck   (i_dmemAck),
        .i_haltReq   (i_haltReq),
        .i_resume    (i_resume),
        .i_ecallAck  (i_ecallAck),
        .o_ifetchReq (o_ifetchReq),
        .o_irLoad    (o_irLoad),
        .o_dmemReq   (o_dmemReq),
        .o_dmemWe    (o_dmemWe),
        .o_regWe     (o_regWe),
        .o_pcUpdate  (o_pcUpdate),
        .o_retire    (o_retire),
        .o_ctrlLat   (o_ctrlLat),
        .o_halted    (o_halted),
        .o_ecall     (o_ecall),
        .o_busErr    (o_busErr)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [9:0] outs();
        return {o_ifetchReq, o_irLoad, o_dmemReq, o_dmemWe, o_regWe,
                o_pcUpdate, o_retire, o_halted, o_ecall, o_busErr};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Complete a zero-wait fetch of word w; returns sampled in DECODE.
    task automatic fetch_issue(input logic [12:0] w);
        i_ctrlSigs  = w;
        i_ifetchAck = 1'b1;
        tick();
        i_ifetchAck = 1'b0;
    endtask

    task automatic test_reset();
        #3 i_rstn = 1'b0;
        #1;
        n_checks++;
        if (outs() !== O_NONE) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", outs(), O_NONE);
        end
        n_checks++;
        if (o_ctrlLat !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h want 0", o_ctrlLat);
        end
        repeat (2) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        #1;
        n_checks++;
        if (outs() !== O_NONE) begin
            n_fail++;
            $display("FAIL idle_cyc0: got %b want %b", outs(), O_NONE);
        end
        tick();
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL fetch_cyc1: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_addi();
        i_ctrlSigs  = W_ADDI;
        i_ifetchAck = 1'b1;
        #1;
        n_checks++;
        if (outs() !== O_FACK) begin
            n_fail++;
            $display("FAIL addi_irload: got %b want %b", outs(), O_FACK);
        end
        tick();
        i_ifetchAck = 1'b0;
        n_checks++;
        if (outs() !== O_NONE) begin
            n_fail++;
            $display("FAIL addi_decode: got %b want %b", outs(), O_NONE);
        end
        tick();
        n_checks++;
        if (outs() !== O_NONE || o_ctrlLat !== W_ADDI) begin
            n_fail++;
            $display("FAIL addi_exec: got %b/%h want %b/%h",
                     outs(), o_ctrlLat, O_NONE, W_ADDI);
        end
        tick();
        n_checks++;
        if (outs() !== O_WBRW) begin
            n_fail++;
            $display("FAIL addi_wb_cyc4: got %b want %b", outs(), O_WBRW);
        end
        tick();
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL addi_fetch_cyc5: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_load();
        fetch_issue(W_LW);
        tick();
        n_checks++;
        if (o_ctrlLat !== W_LW) begin
            n_fail++;
            $display("FAIL lw_ctrllat: got %h want %h", o_ctrlLat, W_LW);
        end
        tick();
        n_checks++;
        if (outs() !== O_MEMR) begin
            n_fail++;
            $display("FAIL lw_mem1: got %b want %b", outs(), O_MEMR);
        end
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_checks++;
            if (outs() !== O_MEMR) begin
                n_fail++;
                $display("FAIL lw_mem%0d: got %b want %b", i, outs(), O_MEMR);
            end
        end
        i_dmemAck = 1'b1;
        tick();
        i_dmemAck = 1'b0;
        n_checks++;
        if (outs() !== O_WBRW) begin
            n_fail++;
            $display("FAIL lw_wb: got %b want %b", outs(), O_WBRW);
        end
        tick();
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL lw_refetch: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_store();
        fetch_issue(W_SW);
        tick();
        tick();
        n_checks++;
        if (outs() !== O_MEMW) begin
            n_fail++;
            $display("FAIL sw_mem: got %b want %b", outs(), O_MEMW);
        end
        i_dmemAck = 1'b1;
        tick();
        i_dmemAck = 1'b0;
        n_checks++;
        if (outs() !== O_WB) begin
            n_fail++;
            $display("FAIL sw_wb: got %b want %b", outs(), O_WB);
        end
        tick();
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL sw_refetch: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_stray();
        i_dmemAck  = 1'b1;
        i_resume   = 1'b1;
        i_ecallAck = 1'b1;
        tick();
        i_dmemAck  = 1'b0;
        i_resume   = 1'b0;
        i_ecallAck = 1'b0;
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL stray_in_fetch: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_brk();
        fetch_issue(W_BRK);
        tick();
        n_checks++;
        if (outs() !== O_HALT) begin
            n_fail++;
            $display("FAIL brk_halt: got %b want %b", outs(), O_HALT);
        end
        i_haltReq = 1'b1;
        tick();
        i_haltReq = 1'b0;
        n_checks++;
        if (outs() !== O_HALT) begin
            n_fail++;
            $display("FAIL brk_hold: got %b want %b", outs(), O_HALT);
        end
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0;
        n_checks++;
        if (outs() !== O_WB) begin
            n_fail++;
            $display("FAIL brk_retire: got %b want %b", outs(), O_WB);
        end
        tick();
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL brk_refetch: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_ecall();
        fetch_issue(W_SYS);
        for (int i = 1; i <= 10; i++) begin
            i_resume = (i == 5);
            tick();
            n_checks++;
            if (outs() !== O_ECALL) begin
                n_fail++;
                $display("FAIL ecall_cyc%0d: got %b want %b",
                         i, outs(), O_ECALL);
            end
        end
        i_resume   = 1'b0;
        i_ecallAck = 1'b1;
        tick();
        i_ecallAck = 1'b0;
        n_checks++;
        if (outs() !== O_WB) begin
            n_fail++;
            $display("FAIL ecall_retire: got %b want %b", outs(), O_WB);
        end
        tick();
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL ecall_refetch: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_ext_halt();
        fetch_issue(W_ADDI);
        i_haltReq = 1'b1;
        tick();
        tick();
        n_checks++;
        if (outs() !== O_WBRW) begin
            n_fail++;
            $display("FAIL ext_wb: got %b want %b", outs(), O_WBRW);
        end
        tick();
        i_haltReq = 1'b0;
        n_checks++;
        if (outs() !== O_HALT) begin
            n_fail++;
            $display("FAIL ext_halt: got %b want %b", outs(), O_HALT);
        end
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0;
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL ext_resume: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_reset_mid_mem();
        fetch_issue(W_LW);
        tick();
        tick();
        n_checks++;
        if (outs() !== O_MEMR) begin
            n_fail++;
            $display("FAIL rst_pre_mem: got %b want %b", outs(), O_MEMR);
        end
        #2 i_rstn = 1'b0;
        #1;
        n_checks++;
        if (outs() !== O_NONE || o_ctrlLat !== 13'h0) begin
            n_fail++;
            $display("FAIL rst_mid_mem: got %b/%h want %b/0",
                     outs(), o_ctrlLat, O_NONE);
        end
        @(posedge i_clk);
        #1 i_rstn = 1'b1;
        #1;
        n_checks++;
        if (outs() !== O_NONE) begin
            n_fail++;
            $display("FAIL rst_idle: got %b want %b", outs(), O_NONE);
        end
        tick();
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL rst_refetch: got %b want %b", outs(), O_FETCH);
        end
    endtask

    task automatic test_bus_timeout();
`ifdef SEQ_BUS_TIMEOUT_EN
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_checks++;
            if (outs() !== O_FETCH) begin
                n_fail++;
                $display("FAIL to_wait%0d: got %b want %b", i, outs(), O_FETCH);
            end
        end
        tick();
        n_checks++;
        if (outs() !== O_HBUS) begin
            n_fail++;
            $display("FAIL to_halt: got %b want %b", outs(), O_HBUS);
        end
        i_resume = 1'b1;
        tick();
        i_resume = 1'b0;
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL to_resume: got %b want %b", outs(), O_FETCH);
        end
        repeat (3) tick();
        i_ctrlSigs  = W_ADDI;
        i_ifetchAck = 1'b1;
        #1;
        n_checks++;
        if (outs() !== O_FACK) begin
            n_fail++;
            $display("FAIL to_limit_ack: got %b want %b", outs(), O_FACK);
        end
        tick();
        i_ifetchAck = 1'b0;
        n_checks++;
        if (outs() !== O_NONE) begin
            n_fail++;
            $display("FAIL to_ack_wins: got %b want %b", outs(), O_NONE);
        end
`else
        repeat (300) tick();
        n_checks++;
        if (outs() !== O_FETCH) begin
            n_fail++;
            $display("FAIL nto_wait: got %b want %b", outs(), O_FETCH);
        end
        fetch_issue(W_ADDI);
        n_checks++;
        if (outs() !== O_NONE) begin
            n_fail++;
            $display("FAIL nto_decode: got %b want %b", outs(), O_NONE);
        end
`endif
        tick();
        tick();
        n_checks++;
        if (outs() !== O_WBRW) begin
            n_fail++;
            $display("FAIL bus_final_wb: got %b want %b", outs(), O_WBRW);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_store();
        test_stray();
        test_brk();
        test_ecall();
        test_ext_halt();
        test_reset_mid_mem();
        test_bus_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
